// File: rtl/dma_pkg.sv
// dma_pkg: shared constants for the cycle-stealing DMA.
// Register offsets, CTRL bit positions, FSM states.
package dma_pkg;

  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN_L = 3'd4;
  localparam logic [2:0] REG_LEN_H = 3'd5;
  localparam logic [2:0] REG_CTRL  = 3'd6;
  localparam logic [2:0] REG_RSVD  = 3'd7;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_SRC_FIX = 2;
  localparam int CTRL_DST_FIX = 3;
  localparam int CTRL_DONE    = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACQ,
    S_RD,
    S_CAP,
    S_WR,
    S_REL,
    S_YIELD
  } state_t;

endpackage

// File: rtl/dma_regfile.sv
// dma_regfile: CPU register slave for the DMA.
// Holds SRC/DST/LEN, CTRL bits, done and irq.
module dma_regfile
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [7:0]  din,
  input  logic        busy,
  input  logic        step,
  input  logic        set_done,
  output logic [7:0]  dout,
  output logic        start,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [15:0] len,
  output logic        src_fixed,
  output logic        dst_fixed,
  output logic        irq
);

  logic       irq_en;
  logic       done;
  logic       wr_en;
  logic       ctrl_wr;
  logic [7:0] rdata;

  assign ctrl_wr = cs & we & (rs == REG_CTRL);
  assign wr_en   = cs & we & ~busy;
  assign start   = ctrl_wr & ~busy & din[CTRL_START];
  assign irq     = done & irq_en;

  // Live read mux; SRC/DST/LEN reflect transfer progress.
  always_comb begin
    rdata = 8'h00;
    unique case (rs)
      REG_SRC_L: rdata = src[7:0];
      REG_SRC_H: rdata = src[15:8];
      REG_DST_L: rdata = dst[7:0];
      REG_DST_H: rdata = dst[15:8];
      REG_LEN_L: rdata = len[7:0];
      REG_LEN_H: rdata = len[15:8];
      REG_CTRL:  rdata = {done, 3'b000,
                          dst_fixed, src_fixed,
                          irq_en, busy};
      REG_RSVD:  rdata = 8'h00;
      default:   rdata = 8'h00;
    endcase
  end

  // Pointer/length registers: CPU loads when idle, FSM steps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src <= '0;
      dst <= '0;
      len <= '0;
    end else if (step) begin
      if (!src_fixed) src <= src + 16'd1;
      if (!dst_fixed) dst <= dst + 16'd1;
      len <= len - 16'd1;
    end else if (wr_en) begin
      unique case (rs)
        REG_SRC_L: src[7:0]  <= din;
        REG_SRC_H: src[15:8] <= din;
        REG_DST_L: dst[7:0]  <= din;
        REG_DST_H: dst[15:8] <= din;
        REG_LEN_L: len[7:0]  <= din;
        REG_LEN_H: len[15:8] <= din;
        default: ;
      endcase
    end
  end

  // CTRL mode bits; frozen while a transfer runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en    <= 1'b0;
      src_fixed <= 1'b0;
      dst_fixed <= 1'b0;
    end else if (ctrl_wr && !busy) begin
      irq_en    <= din[CTRL_IRQ_EN];
      src_fixed <= din[CTRL_SRC_FIX];
      dst_fixed <= din[CTRL_DST_FIX];
    end
  end

  // Done flag: completion set beats a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else if (set_done) begin
      done <= 1'b1;
    end else if (ctrl_wr && din[CTRL_DONE]) begin
      done <= 1'b0;
    end
  end

  // Registered read data, matching the SoC data mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout <= 8'h00;
    end else if (cs && !we) begin
      dout <= rdata;
    end
  end

endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: cycle-stealing DMA, second bus master.
// Halts the CPU via RDY and copies bytes in bursts.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int BURST     = 16,
  parameter int YIELD_CYC = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        cpu_rdy,
  output logic        bus_grant,
  output logic [15:0] dma_ab,
  output logic [7:0]  dma_do,
  output logic        dma_we,
  input  logic [7:0]  dma_di,
  output logic        irq
);

  state_t      state;
  state_t      nxt;
  logic        busy;
  logic        step;
  logic        set_done;
  logic        start;
  logic        last;
  logic        len_zero;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] len;
  logic        src_fixed;
  logic        dst_fixed;
  logic [7:0]  bcnt;
  logic [7:0]  ycnt;
  logic [7:0]  data;

  assign busy     = (state != S_IDLE);
  assign step     = (state == S_WR);
  assign len_zero = (len == 16'd0);
  assign last     = (len == 16'd1) ||
                    (bcnt == 8'(BURST - 1));
  assign set_done =
    ((state == S_REL) && len_zero) ||
    ((state == S_IDLE) && start && len_zero);

  dma_regfile u_regs (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .we        (we),
    .rs        (rs),
    .din       (din),
    .busy      (busy),
    .step      (step),
    .set_done  (set_done),
    .dout      (dout),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .src_fixed (src_fixed),
    .dst_fixed (dst_fixed),
    .irq       (irq)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state: acquire, 3-cycle byte loop, release, yield.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start && !len_zero) nxt = S_ACQ;
      S_ACQ:   nxt = S_RD;
      S_RD:    nxt = S_CAP;
      S_CAP:   nxt = S_WR;
      S_WR:    nxt = last ? S_REL : S_RD;
      S_REL:   nxt = len_zero ? S_IDLE : S_YIELD;
      S_YIELD: if (ycnt == 8'(YIELD_CYC - 1))
                 nxt = S_ACQ;
      default: nxt = S_IDLE;
    endcase
  end

  // Burst/yield counters and the captured data byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt <= 8'h00;
      ycnt <= 8'h00;
      data <= 8'h00;
    end else begin
      if (nxt == S_ACQ)      bcnt <= 8'h00;
      else if (state == S_WR) bcnt <= bcnt + 8'd1;
      if (state == S_YIELD) ycnt <= ycnt + 8'd1;
      else                  ycnt <= 8'h00;
      if (state == S_CAP) data <= dma_di;
    end
  end

  // Master outputs decode from state and registers only.
  always_comb begin
    cpu_rdy   = (state == S_IDLE) ||
                (state == S_YIELD);
    bus_grant = (state == S_RD)  ||
                (state == S_CAP) ||
                (state == S_WR);
    dma_we    = (state == S_WR);
    dma_ab    = (state == S_WR) ? dst : src;
    dma_do    = data;
  end

endmodule

// File: tb/tb_dma_ctrl.sv
// tb_dma_ctrl: directed checks for dma_ctrl.
// Bench models a registered SoC memory behind the master.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  rs = 3'd0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        cpu_rdy;
  logic        bus_grant;
  logic [15:0] dma_ab;
  logic [7:0]  dma_do;
  logic        dma_we;
  logic [7:0]  dma_di = 8'h00;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  gpio_q[$];
  int          lo_q[$];
  int          hi_q[$];
  logic [15:0] rd_q[$];
  int          lo_n = 0;
  int          hi_n = 0;
  int          wr_n = 0;
  bit          in_rd = 0;
  bit          grant_seen = 0;

  dma_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .we        (we),
    .rs        (rs),
    .din       (din),
    .dout      (dout),
    .cpu_rdy   (cpu_rdy),
    .bus_grant (bus_grant),
    .dma_ab    (dma_ab),
    .dma_do    (dma_do),
    .dma_we    (dma_we),
    .dma_di    (dma_di),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Registered memory plus GPIO write log.
  always @(posedge clk) begin
    dma_di <= mem[dma_ab];
    if (bus_grant && dma_we) begin
      mem[dma_ab] <= dma_do;
      if (dma_ab == 16'h1000)
        gpio_q.push_back(dma_do);
    end
  end

  // Bus monitor: stall runs, RD addresses, writes.
  always @(posedge clk) begin
    if (!cpu_rdy) begin
      if (lo_n == 0) hi_q.push_back(hi_n);
      lo_n++;
      hi_n = 0;
    end else begin
      if (lo_n != 0) lo_q.push_back(lo_n);
      lo_n = 0;
      hi_n++;
    end
    if (bus_grant) grant_seen = 1;
    if (bus_grant && !dma_we) begin
      if (!in_rd) rd_q.push_back(dma_ab);
      in_rd = 1;
    end else begin
      in_rd = 0;
    end
    if (bus_grant && dma_we) wr_n++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a,
                        input logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 1; rs = a; din = d;
    @(posedge clk);
    #1;
    cs = 0; we = 0;
  endtask

  task automatic rd_reg(input logic [2:0] a,
                        output logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 0; rs = a;
    @(posedge clk);
    #1;
    cs = 0;
    d = dout;
  endtask

  task automatic setup(input logic [15:0] s,
                       input logic [15:0] d,
                       input logic [15:0] n);
    wr_reg(3'd0, s[7:0]);
    wr_reg(3'd1, s[15:8]);
    wr_reg(3'd2, d[7:0]);
    wr_reg(3'd3, d[15:8]);
    wr_reg(3'd4, n[7:0]);
    wr_reg(3'd5, n[15:8]);
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] v;
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      rd_reg(3'd6, v);
      ok = v[7];
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic clr_mon();
    @(negedge clk);
    lo_q.delete();
    hi_q.delete();
    rd_q.delete();
    gpio_q.delete();
    hi_n = 0;
    wr_n = 0;
    grant_seen = 0;
  endtask

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    int          bad;
    int          hi1;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;
    for (int i = 0; i < 20; i++)
      mem[16'h0300 + i] = 8'(i) ^ 8'h5A;
    mem[16'hF000] = 8'hAA;
    mem[16'hF001] = 8'h55;
    mem[16'hF002] = 8'h0F;
    mem[16'hFFFF] = 8'hC3;
    mem[16'h0000] = 8'h3C;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",   32'(cpu_rdy),   32'd1);
    check("rst_grant", 32'(bus_grant), 32'd0);
    check("rst_we",    32'(dma_we),    32'd0);
    check("rst_ab",    32'(dma_ab),    32'd0);
    check("rst_do",    32'(dma_do),    32'd0);
    check("rst_dout",  32'(dout),      32'd0);
    check("rst_irq",   32'(irq),       32'd0);
    @(negedge clk);
    reset = 0;

    // 4-byte copy with irq enabled
    setup(16'h0100, 16'h0200, 16'd4);
    clr_mon();
    wr_reg(3'd6, 8'h03);
    check("t1_acq_rdy", 32'(cpu_rdy), 32'd0);
    check("t1_acq_gnt", 32'(bus_grant), 32'd0);
    repeat (13) @(posedge clk);
    #1;
    check("t1_irq_13", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    check("t1_irq_14", 32'(irq), 32'd1);
    check("t1_data",
          {mem[16'h0200], mem[16'h0201],
           mem[16'h0202], mem[16'h0203]},
          32'h11223344);
    rd_reg(3'd0, a);
    rd_reg(3'd1, b);
    check("t1_src", {16'h0, b, a}, 32'h0104);
    rd_reg(3'd4, a);
    rd_reg(3'd5, b);
    check("t1_len", {16'h0, b, a}, 32'h0);
    rd_reg(3'd6, a);
    check("t1_ctrl", 32'(a), 32'h82);
    check("t1_stall", 32'(lo_q.size() > 0 ?
          lo_q[0] : -1), 32'd14);
    wr_reg(3'd6, 8'h80);
    check("t1_irq_clr", 32'(irq), 32'd0);

    // 20 bytes split into 16 + 4 bursts
    setup(16'h0300, 16'h0400, 16'd20);
    clr_mon();
    wr_reg(3'd6, 8'h01);
    wait_done("t2_done");
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (mem[16'h0400 + i] !== (8'(i) ^ 8'h5A))
        bad++;
    check("t2_data", 32'(bad), 32'd0);
    check("t2_writes", 32'(wr_n), 32'd20);
    check("t2_nstall", 32'(lo_q.size()), 32'd2);
    check("t2_stall0", 32'(lo_q.size() > 0 ?
          lo_q[0] : -1), 32'd50);
    check("t2_stall1", 32'(lo_q.size() > 1 ?
          lo_q[1] : -1), 32'd14);
    hi1 = (hi_q.size() > 1) ? hi_q[1] : -1;
    check("t2_yield", 32'(hi1), 32'd2);
    wr_reg(3'd6, 8'h80);

    // dst_fixed ROM to GPIO
    setup(16'hF000, 16'h1000, 16'd3);
    clr_mon();
    wr_reg(3'd6, 8'h09);
    wait_done("t3_done");
    check("t3_ngpio", 32'(gpio_q.size()), 32'd3);
    check("t3_gpio",
          gpio_q.size() == 3 ?
          {8'h0, gpio_q[0], gpio_q[1], gpio_q[2]} :
          32'hFFFFFFFF,
          32'h00AA550F);
    rd_reg(3'd2, a);
    rd_reg(3'd3, b);
    check("t3_dst", {16'h0, b, a}, 32'h1000);
    wr_reg(3'd6, 8'h80);

    // zero-length start
    setup(16'h0100, 16'h0700, 16'd0);
    clr_mon();
    wr_reg(3'd6, 8'h01);
    rd_reg(3'd6, a);
    check("t4_ctrl", 32'(a), 32'h80);
    check("t4_grant", 32'(grant_seen), 32'd0);
    check("t4_rdy", 32'(lo_q.size() + lo_n), 32'd0);
    wr_reg(3'd6, 8'h80);

    // source address wrap
    setup(16'hFFFF, 16'h0500, 16'd2);
    clr_mon();
    wr_reg(3'd6, 8'h01);
    wait_done("t5_done");
    check("t5_nrd", 32'(rd_q.size()), 32'd2);
    check("t5_rd",
          rd_q.size() == 2 ?
          {rd_q[0], rd_q[1]} : 32'h0,
          32'hFFFF0000);
    check("t5_data",
          {16'h0, mem[16'h0500], mem[16'h0501]},
          32'hC33C);
    rd_reg(3'd0, a);
    rd_reg(3'd1, b);
    check("t5_src", {16'h0, b, a}, 32'h0001);
    wr_reg(3'd6, 8'h80);

    // busy-write protection, then async reset
    setup(16'h0100, 16'h0600, 16'd8);
    clr_mon();
    wr_reg(3'd6, 8'h03);
    wr_reg(3'd0, 8'h55);
    wr_reg(3'd6, 8'h01);
    for (int i = 0; i < 50 && wr_n < 2; i++)
      @(negedge clk);
    check("t6_wr2", 32'(wr_n >= 2), 32'd1);
    rd_reg(3'd0, a);
    check("t6_srcl", 32'(a), 32'h02);
    rd_reg(3'd6, a);
    check("t6_ctrl", 32'(a), 32'h03);
    @(negedge clk);
    reset = 1;
    #1;
    check("t6_rst_rdy", 32'(cpu_rdy), 32'd1);
    check("t6_rst_gnt", 32'(bus_grant), 32'd0);
    check("t6_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), a);
      if (a !== 8'h00) bad++;
    end
    check("t6_regs0", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
